// File: rtl/unidade_de_busca.sv
// unidade_de_busca: instruction fetch and sequencing stage of the single-cycle core.
//   Holds the PC, addresses the instruction ROM, splits the fetched word for the
//   control unit and computes the next PC from PCSrc/Tipo_Branch and the ALU flags.
//   It also owns the execution state: it stalls on IN until the operator confirms
//   input and freezes on HALT. commit gates every architectural write.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   instr_mem_addr/data   ROM word address (pc[ADDR_W+1:2]) and combinational read data
//   instr/opcode/f3/f7    fetched word and its decode fields
//   PCSrc, Tipo_Branch    branch/jump request and type (1 beq,2 bne,3 blt,4 bge,6 jal)
//   HALT                  halt instruction
//   zero, neg             ALU flags of rs1-rs2
//   entrada_ok            operator confirm key (debounced level)
//   pc, pc_plus4          current PC and PC+4 (JAL link)
//   commit                current instruction retires this cycle
//   aguardando, parado    waiting for input / halted
module unidade_de_busca #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] instr_mem_addr,
  input  logic [31:0]       instr_mem_data,
  output logic [31:0]       instr,
  output logic [6:0]        opcode,
  output logic [2:0]        f3,
  output logic [6:0]        f7,
  input  logic              PCSrc,
  input  logic [2:0]        Tipo_Branch,
  input  logic              HALT,
  input  logic              zero,
  input  logic              neg,
  input  logic              entrada_ok,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              commit,
  output logic              aguardando,
  output logic              parado
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT_IN = 2'd1,
    S_HALTED  = 2'd2
  } state_t;

  localparam logic [6:0] OP_IN = 7'd55;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic               r_ok_prev;
  logic               w_ok_rise;
  logic               w_taken;
  logic               w_commit;
  logic signed [31:0] w_imm_b;
  logic signed [31:0] w_imm_j;
  logic signed [31:0] w_imm;
  logic [31:0]        w_sum;
  logic [31:0]        w_target;
  logic [31:0]        w_next_pc;

  // Branch condition from the ALU flags; type 5 and 0 are never taken.
  function automatic logic branch_cond(input logic [2:0] tipo, input logic z, input logic n);
    logic c;
    c = 1'b0;
    case (tipo)
      3'd1:    c = z;
      3'd2:    c = ~z;
      3'd3:    c = n;
      3'd4:    c = ~n;
      3'd6:    c = 1'b1;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // ---- fetch / decode (combinational) ----
  assign instr_mem_addr = r_pc[ADDR_W+1:2];
  assign instr          = instr_mem_data;
  assign opcode         = instr_mem_data[6:0];
  assign f3             = instr_mem_data[14:12];
  assign f7             = instr_mem_data[31:25];
  assign pc             = r_pc;
  assign pc_plus4       = r_pc + 32'd4;

  assign w_imm_b = {{19{instr_mem_data[31]}}, instr_mem_data[31], instr_mem_data[7],
                    instr_mem_data[30:25], instr_mem_data[11:8], 1'b0};
  assign w_imm_j = {{11{instr_mem_data[31]}}, instr_mem_data[31], instr_mem_data[19:12],
                    instr_mem_data[20], instr_mem_data[30:21], 1'b0};
  assign w_imm   = (Tipo_Branch == 3'd6) ? w_imm_j : w_imm_b;

  // Target is forced word aligned so a malformed immediate can never misalign the PC.
  assign w_sum     = r_pc + $unsigned(w_imm);
  assign w_target  = {w_sum[31:2], 2'b00};
  assign w_taken   = PCSrc & branch_cond(Tipo_Branch, zero, neg);
  assign w_next_pc = w_taken ? w_target : pc_plus4;

  // ok_prev resets to 1 so a key already held during reset is not a rising edge.
  assign w_ok_rise = entrada_ok & ~r_ok_prev;

  // ---- sequencing ----
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_commit    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (HALT) begin
          // HALT itself retires (its writes, if any, are allowed) but the PC freezes.
          w_state_nxt = S_HALTED;
          w_commit    = 1'b1;
        end else if ((opcode == OP_IN) && !w_ok_rise) begin
          w_state_nxt = S_WAIT_IN;
        end else begin
          w_pc_nxt = w_next_pc;
          w_commit = 1'b1;
        end
      end
      S_WAIT_IN: begin
        if (w_ok_rise) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = pc_plus4;
          w_commit    = 1'b1;
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  assign commit     = w_commit;
  assign aguardando = (r_state == S_WAIT_IN);
  assign parado     = (r_state == S_HALTED);

  // ---- state registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_pc      <= RESET_PC;
      r_ok_prev <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ok_prev <= entrada_ok;
    end
  end

endmodule
